// File: rtl/img_stream_loader.sv
// img_stream_loader
// Accepts an 8-bit pixel stream over valid/ready and writes it row-major into
// the shared single-port BRAM starting at a programmable base address.
// It pulses load_done when the frame is complete, and it flags framing errors
// and illegal image dimensions.
// Optional build macro: LOADER_BINARIZE_EN. When it is defined, each pixel is
// thresholded against THRESH to 8'h00 or 8'hFF before it is written.

module img_stream_loader #(
    parameter int                ADDR_W  = 17,
    parameter int                DATA_W  = 8,
    parameter int                MAX_DIM = 256,
    parameter logic [DATA_W-1:0] THRESH  = 8'h80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        img_dim,
    input  logic [ADDR_W-1:0] in_img_start_addr,
    input  logic              start,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic              enb,
    output logic              web,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              load_done,
    output logic              err_tlast,
    output logic              err_dim
);

    // CHECK is the cycle after start in which the latched dimension is
    // validated. Because of it, a rejected or empty frame reports load_done
    // two cycles after start.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          dim_q, dim_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [16:0]         total_q, total_d;
    logic [16:0]         idx_q, idx_d;
    logic                enb_q, enb_d;
    logic                web_q, web_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_tlast_q, err_tlast_d;
    logic                err_dim_q, err_dim_d;

    logic                accept;
    logic                last_pix;
    logic [DATA_W-1:0]   pix_val;

`ifdef LOADER_BINARIZE_EN
    assign pix_val = (s_tdata >= THRESH) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign pix_val       = s_tdata;
`endif

    assign s_tready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_CHECK) || (state_q == ST_LOAD);
    assign load_done = (state_q == ST_DONE);
    assign accept    = s_tvalid && s_tready;
    assign last_pix  = (idx_q == (total_q - 17'd1));

    assign enb       = enb_q;
    assign web       = web_q;
    assign wdata     = wdata_q;
    assign addr      = addr_q;
    assign err_tlast = err_tlast_q;
    assign err_dim   = err_dim_q;

    // Next-state, counters, registered BRAM drive and error flags.
    always_comb begin
        // NOTE: every variable gets a default first so that no path leaves one
        // unassigned. An unassigned path would infer a latch.
        state_d     = state_q;
        dim_d       = dim_q;
        base_d      = base_q;
        total_d     = total_q;
        idx_d       = idx_q;
        enb_d       = 1'b0;
        web_d       = 1'b0;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        err_tlast_d = err_tlast_q;
        err_dim_d   = err_dim_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dim_d       = img_dim;
                    base_d      = in_img_start_addr;
                    err_tlast_d = 1'b0;
                    err_dim_d   = 1'b0;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                idx_d = '0;
                if (dim_q == 9'd0) begin
                    state_d = ST_DONE;
                end else if (dim_q > 9'(MAX_DIM)) begin
                    err_dim_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    total_d = 17'(dim_q) * 17'(dim_q);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    enb_d   = 1'b1;
                    web_d   = 1'b1;
                    addr_d  = base_q + ADDR_W'(idx_q);
                    wdata_d = pix_val;
                    idx_d   = idx_q + 17'd1;
                    if (last_pix) begin
                        if (!s_tlast) err_tlast_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (s_tlast) begin
                        err_tlast_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dim_q       <= '0;
            base_q      <= '0;
            total_q     <= '0;
            idx_q       <= '0;
            enb_q       <= 1'b0;
            web_q       <= 1'b0;
            wdata_q     <= '0;
            addr_q      <= '0;
            err_tlast_q <= 1'b0;
            err_dim_q   <= 1'b0;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments
            // so that every flop samples values from before the clock edge.
            state_q     <= state_d;
            dim_q       <= dim_d;
            base_q      <= base_d;
            total_q     <= total_d;
            idx_q       <= idx_d;
            enb_q       <= enb_d;
            web_q       <= web_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            err_tlast_q <= err_tlast_d;
            err_dim_q   <= err_dim_d;
        end
    end

endmodule

// File: tb/tb_img_stream_loader.sv
// Directed testbench for img_stream_loader.
// Captures BRAM writes and load_done pulses on the falling clock edge. Each
// scenario task checks its own results against hand-derived expectations.

module tb_img_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  img_dim = '0;
    logic [16:0] in_img_start_addr = '0;
    logic        start = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        enb, web;
    logic [7:0]  wdata;
    logic [16:0] addr;
    logic        busy, load_done, err_tlast, err_dim;

    int tests_run = 0;
    int tests_failed = 0;
    int timeouts = 0;
    int done_cnt = 0;

    logic [16:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [16:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];

    img_stream_loader dut (
        .clk(clk), .rst_n(rst_n), .img_dim(img_dim),
        .in_img_start_addr(in_img_start_addr), .start(start),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .enb(enb), .web(web), .wdata(wdata), .addr(addr),
        .busy(busy), .load_done(load_done), .err_tlast(err_tlast),
        .err_dim(err_dim)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write and done monitor.
    always @(negedge clk) begin
        if (enb && web) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wdata);
        end
        if (load_done) done_cnt++;
    end

    function automatic logic [7:0] exp_pix(input logic [7:0] d);
`ifdef LOADER_BINARIZE_EN
        return (d >= 8'h80) ? 8'hFF : 8'h00;
`else
        return d;
`endif
    endfunction

    function automatic int count_mismatch();
        int n = 0;
        int sz = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < sz; i++)
            if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) n++;
        n += (wr_addr_q.size() > exp_addr_q.size()) ? wr_addr_q.size() - exp_addr_q.size()
                                                    : exp_addr_q.size() - wr_addr_q.size();
        return n;
    endfunction

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete();
        exp_addr_q.delete(); exp_data_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [8:0] dim, input logic [16:0] base);
        img_dim = dim;
        in_img_start_addr = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        img_dim = 9'h1AA;
        in_img_start_addr = 17'h15555;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic last, input logic [16:0] a);
        bit acc = 0;
        bit ok = 0;
        s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            if (acc) begin ok = 1; break; end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        if (!ok) timeouts++;
        exp_addr_q.push_back(a);
        exp_data_q.push_back(exp_pix(d));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({s_tready, enb, web, wdata, addr, busy, load_done, err_tlast, err_dim} !== '0) begin
            tests_failed++;
            $display("FAIL reset_during: outputs=%h expected 0",
                     {s_tready, enb, web, wdata, addr, busy, load_done, err_tlast, err_dim});
        end
        @(negedge clk); rst_n = 1'b1;
        idle_cycles(2);
        tests_run++;
        if ({s_tready, enb, web, busy, load_done, err_tlast, err_dim} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle: ctl=%b expected 0",
                     {s_tready, enb, web, busy, load_done, err_tlast, err_dim});
        end
    endtask

    task automatic full_load(input string tag, input logic [16:0] base);
        clear_mon();
        do_start(9'h040, base);
        for (int i = 0; i < 4096; i++)
            send_pix(i[7:0], i == 4095, base + 17'(i));
        tests_run++;
        if ({load_done, enb, web} !== 3'b111 || addr !== base + 17'd4095) begin
            tests_failed++;
            $display("FAIL %s_last_write: done/enb/web=%b addr=%h expected 111 addr=%h",
                     tag, {load_done, enb, web}, addr, base + 17'd4095);
        end
        idle_cycles(1);
        tests_run++;
        if ({load_done, busy, s_tready} !== 3'b000) begin
            tests_failed++;
            $display("FAIL %s_after_done: done/busy/ready=%b expected 000", tag,
                     {load_done, busy, s_tready});
        end
        idle_cycles(3);
        tests_run++;
        if (count_mismatch() != 0 || wr_addr_q.size() != 4096) begin
            tests_failed++;
            $display("FAIL %s_writes: got %0d writes, %0d mismatches; expected 4096, 0", tag,
                     wr_addr_q.size(), count_mismatch());
        end
        tests_run++;
        if (done_cnt != 1 || {err_tlast, err_dim} !== 2'b00 || timeouts != 0) begin
            tests_failed++;
            $display("FAIL %s_status: done_cnt=%0d errs=%b timeouts=%0d expected 1 00 0",
                     tag, done_cnt, {err_tlast, err_dim}, timeouts);
        end
    endtask

    task automatic test_full_frame();
        full_load("full_frame", 17'h00000);
    endtask

    task automatic test_gaps();
        int gap_enb = 0;
        clear_mon();
        do_start(9'd4, 17'h1FFFE);
        for (int i = 0; i < 16; i++) begin
            send_pix(8'(i * 17 + 3), i == 15, 17'h1FFFE + 17'(i));
            if ((i % 3) == 1 && i < 15) begin
                // A stray start in a gap must be ignored.
                if (i == 4) begin img_dim = 9'd2; start = 1'b1; end
                @(posedge clk); #1;
                start = 1'b0;
                if (enb !== 1'b0) gap_enb++;
            end
        end
        idle_cycles(3);
        tests_run++;
        if (gap_enb != 0) begin
            tests_failed++;
            $display("FAIL gaps_enb: enb high in %0d gap cycles, expected 0", gap_enb);
        end
        tests_run++;
        if (count_mismatch() != 0 || wr_addr_q.size() != 16) begin
            tests_failed++;
            $display("FAIL gaps_writes: got %0d writes, %0d mismatches; expected 16, 0",
                     wr_addr_q.size(), count_mismatch());
        end
        tests_run++;
        if (done_cnt != 1 || {err_tlast, err_dim} !== 2'b00 || timeouts != 0) begin
            tests_failed++;
            $display("FAIL gaps_status: done_cnt=%0d errs=%b timeouts=%0d expected 1 00 0",
                     done_cnt, {err_tlast, err_dim}, timeouts);
        end
    endtask

    task automatic test_tlast_err();
        clear_mon();
        do_start(9'd4, 17'h00100);
        for (int i = 0; i < 10; i++) send_pix(8'(8'h40 + i), i == 9, 17'h00100 + 17'(i));
        tests_run++;
        if (load_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL early_tlast_done: load_done=%b expected 1", load_done);
        end
        idle_cycles(3);
        tests_run++;
        if (err_tlast !== 1'b1 || s_tready !== 1'b0 || done_cnt != 1 ||
            count_mismatch() != 0 || wr_addr_q.size() != 10) begin
            tests_failed++;
            $display("FAIL early_tlast: err=%b ready=%b done_cnt=%0d writes=%0d mism=%0d expected 1 0 1 10 0",
                     err_tlast, s_tready, done_cnt, wr_addr_q.size(), count_mismatch());
        end
        clear_mon();
        do_start(9'd2, 17'h00200);
        tests_run++;
        if (err_tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL tlast_clear: err_tlast=%b expected 0", err_tlast);
        end
        for (int i = 0; i < 4; i++) send_pix(8'(8'h90 + i), i == 3, 17'h00200 + 17'(i));
        idle_cycles(3);
        tests_run++;
        if (err_tlast !== 1'b0 || done_cnt != 1 || count_mismatch() != 0 || wr_addr_q.size() != 4) begin
            tests_failed++;
            $display("FAIL dim2_load: err=%b done_cnt=%0d writes=%0d mism=%0d expected 0 1 4 0",
                     err_tlast, done_cnt, wr_addr_q.size(), count_mismatch());
        end
        clear_mon();
        do_start(9'd1, 17'h00300);
        send_pix(8'h5A, 1'b0, 17'h00300);
        tests_run++;
        if ({load_done, enb, err_tlast} !== 3'b111) begin
            tests_failed++;
            $display("FAIL missing_tlast: done/enb/err=%b expected 111", {load_done, enb, err_tlast});
        end
        idle_cycles(2);
        tests_run++;
        if (count_mismatch() != 0 || wr_addr_q.size() != 1 || done_cnt != 1 || timeouts != 0) begin
            tests_failed++;
            $display("FAIL missing_tlast_writes: writes=%0d mism=%0d done_cnt=%0d timeouts=%0d expected 1 0 1 0",
                     wr_addr_q.size(), count_mismatch(), done_cnt, timeouts);
        end
    endtask

    task automatic test_dim();
        clear_mon();
        do_start(9'h101, 17'h00000);
        tests_run++;
        if (load_done !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL dim257_check_cycle: done=%b busy=%b expected 0 1", load_done, busy);
        end
        idle_cycles(1);
        tests_run++;
        if (load_done !== 1'b1 || err_dim !== 1'b1) begin
            tests_failed++;
            $display("FAIL dim257_done: done=%b err_dim=%b expected 1 1", load_done, err_dim);
        end
        idle_cycles(3);
        tests_run++;
        if (wr_addr_q.size() != 0 || done_cnt != 1 || err_dim !== 1'b1) begin
            tests_failed++;
            $display("FAIL dim257_status: writes=%0d done_cnt=%0d err_dim=%b expected 0 1 1",
                     wr_addr_q.size(), done_cnt, err_dim);
        end
        clear_mon();
        do_start(9'd0, 17'h00000);
        idle_cycles(1);
        tests_run++;
        if (load_done !== 1'b1 || {err_dim, err_tlast} !== 2'b00) begin
            tests_failed++;
            $display("FAIL dim0_done: done=%b errs=%b expected 1 00", load_done, {err_dim, err_tlast});
        end
        idle_cycles(3);
        tests_run++;
        if (wr_addr_q.size() != 0 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL dim0_status: writes=%0d done_cnt=%0d expected 0 1", wr_addr_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_mon();
        do_start(9'h040, 17'h01000);
        for (int i = 0; i < 100; i++) send_pix(i[7:0], 1'b0, 17'h01000 + 17'(i));
        s_tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({s_tready, enb, web, wdata, addr, busy, load_done, err_tlast, err_dim} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: outputs=%h expected 0",
                     {s_tready, enb, web, wdata, addr, busy, load_done, err_tlast, err_dim});
        end
        s_tvalid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        idle_cycles(2);
        tests_run++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_nodone: done_cnt=%0d busy=%b expected 0 0", done_cnt, busy);
        end
        full_load("reload", 17'h01000);
    endtask

    task automatic test_pixel_values();
        logic [7:0] px [4];
        logic [7:0] ex [4];
        int bad = 0;
        px[0] = 8'h7F; px[1] = 8'h80; px[2] = 8'hFF; px[3] = 8'h00;
`ifdef LOADER_BINARIZE_EN
        ex[0] = 8'h00; ex[1] = 8'hFF; ex[2] = 8'hFF; ex[3] = 8'h00;
`else
        ex[0] = 8'h7F; ex[1] = 8'h80; ex[2] = 8'hFF; ex[3] = 8'h00;
`endif
        clear_mon();
        do_start(9'd2, 17'h00050);
        for (int i = 0; i < 4; i++) send_pix(px[i], i == 3, 17'h00050 + 17'(i));
        idle_cycles(3);
        for (int i = 0; i < 4; i++)
            if (i >= wr_data_q.size() || wr_data_q[i] !== ex[i]) bad++;
        tests_run++;
        if (bad != 0 || wr_data_q.size() != 4) begin
            tests_failed++;
            $display("FAIL pixel_values: %0d wrong of %0d writes, expected 0 of 4", bad, wr_data_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_tlast_err();
        test_dim();
        test_reset_mid_load();
        test_pixel_values();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/img_stream_loader.md
Name: img_stream_loader

Overview:
Upstream loader for the deskew datapath. It accepts an 8-bit grayscale pixel stream over a valid/ready handshake and writes the pixels row-major into the shared single-port BRAM, starting at a programmable base address. When the frame is complete it pulses load_done; the top level uses that pulse to assert start_calc_moments on the deskew datapath. It also flags stream framing errors and illegal image dimensions.

Parameters:
ADDR_W, 17, BRAM address width
DATA_W, 8, pixel/BRAM data width
MAX_DIM, 256, largest legal img_dim
THRESH, 8'h80, binarisation threshold (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
img_dim  in  9  image side length N; frame is N*N pixels; sampled at start
in_img_start_addr  in  ADDR_W  BRAM base address; sampled at start
start  in  1  single-cycle load request
s_tdata  in  DATA_W  pixel data
s_tvalid  in  1  pixel valid
s_tready  out  1  loader ready
s_tlast  in  1  last pixel of frame
enb  out  1  BRAM enable
web  out  1  BRAM write enable
wdata  out  DATA_W  BRAM write data
addr  out  ADDR_W  BRAM address
busy  out  1  load in progress
load_done  out  1  one-cycle pulse at end of load
err_tlast  out  1  sticky framing error; cleared by the next accepted start
err_dim  out  1  sticky illegal-dimension error; cleared by the next accepted start

Behaviour:
- Reset (async assert, sync deassert on clk): FSM=IDLE. All outputs are 0: s_tready, enb, web, wdata, addr, busy, load_done, err_tlast, err_dim. All counters are 0.
- FSM states:
  - IDLE: s_tready=0. On start, latch img_dim to dim_q and the base address to base_q, and clear both error flags.
    - dim_q==0 -> DONE.
    - dim_q>MAX_DIM -> set err_dim, go to DONE.
    - Otherwise load total=dim_q*dim_q (17-bit product, max 65536), set idx=0, go to LOAD.
  - LOAD: busy=1, s_tready=1. Each accept (s_tvalid&&s_tready) consumes one pixel.
  - DONE: load_done=1 for exactly one cycle; busy=0; return to IDLE.
- Accepting a pixel: all BRAM outputs are registered, so on the cycle after an accept enb=1, web=1, addr=base_q+idx (mod 2^ADDR_W, wraps silently), wdata=pixel. idx then increments by 1.
- If no pixel is accepted in a cycle, enb=0 and web=0 on the next cycle. addr and wdata hold their last values.
- End of frame: on the accept with idx==total-1, the FSM goes to DONE. The final BRAM write and the load_done pulse occur in the same cycle, one cycle after the last accept.
- tlast rules:
  - s_tlast on a pixel with idx<total-1: set err_tlast, write that pixel, go to DONE (early termination).
  - s_tlast=0 on pixel total-1: set err_tlast, still go to DONE.
- The loader does not drop or duplicate pixels. Throughput is one pixel per cycle while s_tvalid stays high.
- start outside IDLE is ignored; the parameters latched for the current load are unaffected.
- A change on img_dim or in_img_start_addr during LOAD has no effect.
- Reset asserted mid-load: immediate return to IDLE with all outputs 0. Partial BRAM contents are not cleaned up, and no load_done is produced.
- The loader drives BRAM only in LOAD and DONE. In IDLE, enb=0, so the top-level mux can hand the port to the deskew datapath.

Optional Feature:
LOADER_BINARIZE_EN
- Defined: wdata = (s_tdata >= THRESH) ? 8'hFF : 8'h00. This is a registered compare; write latency is unchanged.
- Undefined: wdata = s_tdata unchanged, and the THRESH parameter is unused.

Test Plan:
1. img_dim=9'h040, base=17'h00000, 4096 back-to-back pixels (value=idx[7:0]), tlast on the last pixel -> writes at addr 0..4095 with matching data, one load_done pulse one cycle after the last accept, err_tlast=0, err_dim=0.
2. img_dim=4, base=17'h1FFFE, random s_tvalid gaps -> 16 writes at addr 1FFFE, 1FFFF, 00000..0000D. enb is low in every gap cycle; data order is preserved.
3. img_dim=4, tlast on pixel 9 -> 10 writes, err_tlast=1, load_done pulses, s_tready=0 afterwards. The next start with img_dim=2 clears err_tlast.
4. img_dim=9'h101 (257) -> no BRAM access, err_dim=1, load_done pulses 2 cycles after start. img_dim=0 -> load_done pulses with no error and no writes.
5. Reset asserted after 100 of 4096 pixels -> all outputs 0 asynchronously. A new start then completes a full load normally.
6. With LOADER_BINARIZE_EN defined and THRESH=8'h80, pixels 7F, 80, FF, 00 -> wdata 00, FF, FF, 00.
